// File: rtl/dram_phase_controller.sv
// DRAM phase controller: UART load, processor run, UART dump.
// Optional DRAM_PHASE_RESTART_EN: DONE returns to LOAD after one cycle.
module dram_phase_controller #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LOAD_BASE  = 0,
    parameter int LOAD_WORDS = 256,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_WORDS = 256,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic              proc_we,
    input  logic              proc_done,
    output logic              proc_en,
    output logic [DATA_W-1:0] proc_rdata,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    input  logic [DATA_W-1:0] dram_q,
    output logic [1:0]        phase,
    output logic              rx_overrun
);

    localparam int CNT_W = $clog2(LOAD_WORDS + 1);
    localparam int IDX_W = $clog2(DUMP_WORDS + 1);

    typedef enum logic [2:0] {
        S_LOAD, S_RUN, S_DADDR, S_DWAIT, S_DSEND, S_DGAP, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_wcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_start;
    logic              r_overrun;

    logic w_load_full;
    logic w_load_acc;
    logic w_last_idx;
    logic w_wait_end;
    logic w_dump;

    assign w_load_full = (r_cnt == CNT_W'(LOAD_WORDS));
    assign w_load_acc  = rx_valid && (r_state == S_LOAD) && !w_load_full;
    assign w_last_idx  = (r_idx == IDX_W'(DUMP_WORDS - 1));
    assign w_wait_end  = (r_wcnt == 8'(RD_LAT - 2));
    assign w_dump      = (r_state == S_DADDR) || (r_state == S_DWAIT) ||
                         (r_state == S_DSEND) || (r_state == S_DGAP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_next;
    end

    // Next-state logic; LOAD leaves one cycle after its last write
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_load_full) w_next = S_RUN;
            S_RUN:   if (proc_done) w_next = S_DADDR;
            S_DADDR: w_next = (RD_LAT == 1) ? S_DSEND : S_DWAIT;
            S_DWAIT: if (w_wait_end) w_next = S_DSEND;
            S_DSEND: if (tx_ready) w_next = S_DGAP;
            S_DGAP:  w_next = w_last_idx ? S_DONE : S_DADDR;
`ifdef DRAM_PHASE_RESTART_EN
            S_DONE:  w_next = S_LOAD;
`else
            S_DONE:  w_next = S_DONE;
`endif
            default: w_next = S_LOAD;
        endcase
    end

    // Counters, registered load write port, transmit strobe, overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wcnt     <= '0;
            r_addr     <= ADDR_W'(LOAD_BASE);
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_tx_start <= 1'b0;
            if (rx_valid && !w_load_acc) r_overrun <= 1'b1;
            case (r_state)
                S_LOAD: begin
                    if (w_load_acc) begin
                        r_addr  <= ADDR_W'(LOAD_BASE) + ADDR_W'(r_cnt);
                        r_wdata <= rx_data;
                        r_we    <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt   <= '0;
                    r_addr  <= ADDR_W'(LOAD_BASE);
                    r_wdata <= '0;
                    if (proc_done) r_idx <= '0;
                end
                S_DADDR: r_wcnt <= '0;
                S_DWAIT: r_wcnt <= r_wcnt + 1'b1;
                S_DSEND: begin
                    r_tx_data <= dram_q;
                    if (tx_ready) r_tx_start <= 1'b1;
                end
                S_DGAP: if (!w_last_idx) r_idx <= r_idx + 1'b1;
                S_DONE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    // DRAM port owner: processor in RUN, dump reader in DUMP, load writer otherwise
    always_comb begin
        dram_addr  = r_addr;
        dram_wdata = r_wdata;
        dram_we    = r_we;
        if (r_state == S_RUN) begin
            dram_addr  = proc_addr;
            dram_wdata = proc_wdata;
            dram_we    = proc_we;
        end else if (w_dump) begin
            dram_addr  = ADDR_W'(DUMP_BASE) + ADDR_W'(r_idx);
            dram_wdata = '0;
            dram_we    = 1'b0;
        end
    end

    // Phase code seen by the rest of the system
    always_comb begin
        phase = 2'd0;
        if (r_state == S_RUN)  phase = 2'd1;
        if (w_dump)            phase = 2'd2;
        if (r_state == S_DONE) phase = 2'd3;
    end

    assign proc_en    = (r_state == S_RUN);
    assign proc_rdata = dram_q;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign rx_overrun = r_overrun;

endmodule

// File: doc/dram_phase_controller.md
# dram_phase_controller

Parametrised sequencer and DRAM port owner for the processor top level. It loads a block of bytes from the UART receiver into DRAM, then hands DRAM to the processor and holds it enabled until the processor reports completion. It then streams a DRAM region out to the UART transmitter one byte at a time. It replaces the fixed two-way DRAM address, data and write-enable muxes with one three-phase controller.

## Interface
- ADDR_W, 16, DRAM address width
- DATA_W, 8, DRAM/UART data width
- LOAD_BASE, 0, first DRAM address written in LOAD
- LOAD_WORDS, 256, bytes accepted in LOAD (≥1)
- DUMP_BASE, 0, first DRAM address read in DUMP
- DUMP_WORDS, 256, bytes transmitted in DUMP (≥1)
- RD_LAT, 2, cycles from dram_addr valid to dram_q valid (≥1)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  DATA_W  received byte
- proc_addr  in  ADDR_W  processor DRAM address
- proc_wdata  in  DATA_W  processor write data
- proc_we  in  1  processor write enable
- proc_done  in  1  processor finished (its start_Tx)
- proc_en  out  1  processor run enable
- proc_rdata  out  DATA_W  dram_q forwarded to processor
- tx_ready  in  1  transmitter idle
- tx_start  out  1  one-cycle transmit strobe
- tx_data  out  DATA_W  byte to transmit, valid with tx_start
- dram_addr  out  ADDR_W  DRAM address
- dram_wdata  out  DATA_W  DRAM write data
- dram_we  out  1  DRAM write enable
- dram_q  in  DATA_W  DRAM read data
- phase  out  2  0 LOAD, 1 RUN, 2 DUMP, 3 DONE
- rx_overrun  out  1  sticky: rx_valid received outside LOAD

## Operation
- States: LOAD → RUN → DUMP_ADDR → DUMP_WAIT → DUMP_SEND → DUMP_GAP → (DUMP_ADDR | DONE).
- LOAD: each rx_valid registers addr = LOAD_BASE+cnt, data = rx_data, we = 1 for exactly one cycle, and increments cnt. The write with cnt = LOAD_WORDS−1 moves the state to RUN.
- RUN: proc_en = 1. dram_addr, dram_wdata and dram_we are combinationally driven from proc_addr, proc_wdata and proc_we. proc_done sampled high moves the state to DUMP_ADDR and clears idx.
- DUMP_ADDR: dram_addr = DUMP_BASE+idx, dram_we = 0. DUMP_WAIT holds RD_LAT−1 cycles. DUMP_SEND captures dram_q into tx_data and waits for tx_ready = 1, then pulses tx_start for one cycle.
- DUMP_GAP: one cycle in which tx_ready is ignored. Then idx++ and return to DUMP_ADDR, or go to DONE after idx = DUMP_WORDS−1.
- proc_rdata = dram_q in every state.
- Outside RUN: proc_we is ignored and proc_en = 0. proc_done is ignored outside RUN.
- rx_valid outside LOAD: no DRAM write; sets rx_overrun (cleared only by rst).
- Addresses are computed modulo 2^ADDR_W, so base+count wraps silently.

## Timing
- Reset values: state LOAD, cnt = idx = 0, proc_en = 0, tx_start = 0, tx_data = 0, dram_addr = LOAD_BASE, dram_wdata = 0, dram_we = 0, phase = 0, rx_overrun = 0. Asserting rst mid-phase forces these values immediately, including dropping dram_we.
- rx_valid at cycle t → dram_we = 1 at t+1. Back-to-back rx_valid pulses produce back-to-back writes.
- Last LOAD write at t+1 → proc_en = 1 and phase = 1 at t+2.
- proc_done high at t → proc_en = 0 and dram_addr = DUMP_BASE at t+1.
- Per byte, with tx_ready held high, the earliest period is RD_LAT+2 cycles.
- proc_done and rx_valid in the same RUN cycle: the transition happens and rx_overrun sets.

## Configuration
- DRAM_PHASE_RESTART_EN defined: DONE lasts one cycle, then the state returns to LOAD with cnt and idx cleared. rx_overrun is preserved.
- Not defined: DONE is terminal until rst. phase holds 3 and all outputs stay at their idle values.

## Test plan
- LOAD_WORDS = 4, LOAD_BASE = 0x10; rx bytes 0xA1..0xA4 one cycle apart → four consecutive dram_we cycles at 0x10..0x13 with data A1..A4; proc_en rises 1 cycle after the last write.
- RUN: processor writes 0x55 to 0x0200, then asserts proc_done → that write passes through in the same cycle; proc_en drops the next cycle; phase = 2.
- DUMP_WORDS = 3 at 0x0200 with the RAM model RD_LAT = 2, tx_ready always 1 → tx_start pulses carry 0x55, mem[0x201], mem[0x202], spaced 4 cycles apart; phase = 3 after the last pulse.
- tx_ready held low for 20 cycles during DUMP_SEND → no tx_start; pulse follows 1 cycle after tx_ready rises, with data unchanged.
- rx_valid during RUN → no DRAM write; rx_overrun = 1 and stays set through DONE.
- rst asserted mid-LOAD after 2 of 4 bytes → dram_we = 0 asynchronously; reload of 4 bytes starts again at LOAD_BASE.
